// File: rtl/seq_mult_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

    localparam int SEQ_MULT_DEFAULT_W = 16;
    localparam int SEQ_MULT_MAX_W     = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Magnitude of a sign-extended operand; the most negative value maps to
    // its own bit pattern, which is the correct unsigned magnitude.
    function automatic logic [SEQ_MULT_MAX_W-1:0] abs_val(input logic signed [SEQ_MULT_MAX_W-1:0] v);
        return v[SEQ_MULT_MAX_W-1] ? SEQ_MULT_MAX_W'(-v) : SEQ_MULT_MAX_W'(v);
    endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier.
interface seq_multiplier_if
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = SEQ_MULT_DEFAULT_W
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/seq_mult_datapath.sv
// Shift-add datapath: operand magnitudes, accumulator and signed fix-up of the result.
// SEQ_MULTIPLIER_EARLY_TERM_EN: flag the last iteration once the multiplier shifts to zero.
module seq_mult_datapath
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = SEQ_MULT_DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 finish,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 early_last,
    output logic [2*WIDTH-1:0]   product
);
    logic signed [WIDTH-1:0]   a_s;
    logic signed [WIDTH-1:0]   b_s;
    logic [WIDTH-1:0]          mag_a;
    logic [WIDTH-1:0]          mag_b;
    logic [2*WIDTH-1:0]        mcand;
    logic [WIDTH-1:0]          mplier;
    logic [2*WIDTH-1:0]        acc;
    logic                      neg;
    logic [2*WIDTH-1:0]        acc_nxt;
    logic [2*WIDTH-1:0]        prod_fin;

    assign a_s   = $signed(a);
    assign b_s   = $signed(b);
    assign mag_a = signed_mode ? WIDTH'(abs_val(SEQ_MULT_MAX_W'(a_s))) : a;
    assign mag_b = signed_mode ? WIDTH'(abs_val(SEQ_MULT_MAX_W'(b_s))) : b;

    assign acc_nxt  = mplier[0] ? acc + mcand : acc;
    // A zero result never picks up the sign, so -0 cannot appear.
    assign prod_fin = (neg && (acc_nxt != '0)) ? -acc_nxt : acc_nxt;

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    assign early_last = (mplier[WIDTH-1:1] == '0);
`else
    assign early_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else if (load) begin
            mcand  <= (2*WIDTH)'(mag_a);
            mplier <= mag_b;
            acc    <= '0;
            neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (step) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            if (finish) begin
                product <= prod_fin;
            end
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier with valid/ready on both sides and per-transaction signed mode.
// SEQ_MULTIPLIER_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = SEQ_MULT_DEFAULT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    seq_multiplier_if.slave bus
);
    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               load;
    logic               step;
    logic               last_iter;
    logic               early_last;

    assign load      = (state == IDLE) && bus.in_valid;
    assign step      = (state == BUSY);
    assign last_iter = (cnt == LAST_CNT) || early_last;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state      <= BUSY;
                        cnt        <= '0;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (last_iter) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    // Re-open for operands only on the cycle after the result is taken.
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    seq_mult_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .step        (step),
        .finish      (step && last_iter),
        .a           (bus.a),
        .b           (bus.b),
        .signed_mode (bus.signed_mode),
        .early_last  (early_last),
        .product     (bus.product)
    );

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier (WIDTH=16) with an expected-product queue.
module tb_seq_multiplier;
    localparam int W   = 16;
    localparam int LIM = 200;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [31:0] exp_q[$];

    seq_multiplier_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int exp_lat(input logic [15:0] bv, input logic sm);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
        logic [15:0] mag;
        int hb;
        mag = (sm && bv[15]) ? 16'(-bv) : bv;
        hb  = 0;
        for (int i = 0; i < 16; i++) if (mag[i]) hb = i + 1;
        return (hb == 0) ? 1 : hb;
`else
        return W;
`endif
    endfunction

    function automatic logic [31:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic sm);
        logic signed [31:0] sa, sb;
        logic [31:0] ua, ub;
        if (sm) begin
            sa = 32'($signed(ma));
            sb = 32'($signed(mb));
            return 32'(sa * sb);
        end
        ua = {16'h0, ma};
        ub = {16'h0, mb};
        return ua * ub;
    endfunction

    task automatic wait_in_ready();
        int waitc;
        waitc = 0;
        while (!bus.in_ready && waitc < LIM) begin
            @(negedge clk);
            waitc++;
        end
        check("in_ready_before_accept", bus.in_ready, 1);
    endtask

    // Accept, then count edges until out_valid shows at a falling edge.
    task automatic accept_and_wait(input logic [15:0] ta, input logic [15:0] tbv, input logic sm,
                                   input logic [31:0] exp, input logic early_rdy);
        int lat;
        @(negedge clk);
        wait_in_ready();
        bus.a = ta; bus.b = tbv; bus.signed_mode = sm; bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        #1;
        bus.in_valid = 1'b0;
        bus.a = 16'($urandom); bus.b = 16'($urandom); bus.signed_mode = ~sm;
        bus.out_ready = early_rdy;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!bus.out_valid && lat < LIM);
        check("latency", lat, exp_lat(tbv, sm));
        check("out_valid_rise", bus.out_valid, 1);
    endtask

    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tbv, input logic sm,
                           input logic [31:0] exp, input logic early_rdy);
        accept_and_wait(ta, tbv, sm, exp, early_rdy);
        check("scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) check("product", bus.product, exp_q.pop_front());
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("out_valid_drop", bus.out_valid, 0);
        check("in_ready_back", bus.in_ready, 1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rs;
        logic [31:0] hold_exp;

        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.signed_mode = 1'b0; bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_product", bus.product, 0);
        rst_n = 1'b1;

        run_txn(16'h0005, 16'h0003, 1'b0, 32'h0000000F, 1'b0);
        run_txn(16'hCA15, 16'h369A, 1'b0, 32'h2B19FEA2, 1'b0);
        run_txn(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 1'b1);
        run_txn(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, 1'b0);
        run_txn(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 1'b0);
        run_txn(16'h8000, 16'h8000, 1'b1, 32'h40000000, 1'b1);
        run_txn(16'h8000, 16'h0000, 1'b1, 32'h00000000, 1'b0);
        run_txn(16'h0007, 16'h0001, 1'b0, 32'h00000007, 1'b0);
        run_txn(16'h0003, 16'h0100, 1'b0, 32'h00000300, 1'b0);
        run_txn(16'h1234, 16'h0000, 1'b0, 32'h00000000, 1'b0);
        run_txn(16'h0000, 16'hFFFE, 1'b1, 32'h00000000, 1'b0);

        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            run_txn(ra, rb, rs, model(ra, rb, rs), 1'($urandom));
        end

        // Backpressure: result held for five cycles, stray operands ignored.
        hold_exp = 32'h00061D78;
        accept_and_wait(16'h1234, 16'h0056, 1'b0, hold_exp, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i != 0) @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_product", bus.product, hold_exp);
            check("bp_in_ready", bus.in_ready, 0);
            bus.in_valid = (i == 2);
            bus.a = 16'hFFFF; bus.b = 16'hFFFF;
        end
        check("bp_scoreboard_depth", exp_q.size(), 1);
        if (exp_q.size() != 0) check("bp_sb_product", bus.product, exp_q.pop_front());
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_release_out_valid", bus.out_valid, 0);
        check("bp_release_in_ready", bus.in_ready, 1);
        check("bp_release_busy", bus.busy, 0);
        repeat (3) begin
            @(negedge clk);
            check("bp_stray_not_taken", bus.busy, 0);
        end
        check("bp_product_held", bus.product, hold_exp);

        // Reset in the middle of a transaction.
        @(negedge clk);
        wait_in_ready();
        bus.a = 16'h1111; bus.b = 16'h2222; bus.signed_mode = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(16'h1111, 16'h2222, 1'b0));
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_in_ready", bus.in_ready, 1);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_product", bus.product, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 2) begin
            @(negedge clk);
            check("post_rst_no_out_valid", bus.out_valid, 0);
        end
        run_txn(16'h0034, 16'h001F, 1'b0, 32'h0000064C, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
